// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two requesters.
// Request sampled in IDLE; ack pulses 3 cycles later; the losing channel waits, held off until the next IDLE.
module mem_rr_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_wr_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_i_data,
  input  logic [DATA_W-1:0] mem_o_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   op_wr;
  logic   pick;

  // On a tie the channel that did not win last time goes next.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last_grant;
    else if (req1)    pick = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_wr      <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
      mem_wr_rd  <= 1'b0;
      mem_addr   <= '0;
      mem_i_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant      <= pick;
            last_grant <= pick;
            op_wr      <= pick ? wr1 : wr0;
            mem_wr_rd  <= pick ? wr1 : wr0;
            mem_addr   <= pick ? addr1 : addr0;
            mem_i_data <= pick ? wdata1 : wdata0;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // RAM acts on this edge; drop back to the harmless read default.
          mem_wr_rd <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          if (grant) begin
            ack1 <= 1'b1;
            if (!op_wr) rdata1 <= mem_o_data;
          end else begin
            ack0 <= 1'b1;
            if (!op_wr) rdata0 <= mem_o_data;
          end
          state <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural registered-read RAM.
module tb_mem_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       req0, wr0, req1, wr1;
  logic [9:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, mem_wr_rd;
  logic [7:0] rdata0, rdata1;
  logic [9:0] mem_addr;
  logic [7:0] mem_i_data, mem_o_data;

  logic [7:0] ram [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_rd) ram[mem_addr] <= mem_i_data;
    mem_o_data <= ram[mem_addr];
  end

  mem_rr_arbiter #(.ADDR_W(10), .DATA_W(8)) dut (
    .clk(clk), .reset_p(reset_p),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
    .mem_i_data(mem_i_data), .mem_o_data(mem_o_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One lone transaction on channel ch, checked cycle by cycle.
  task automatic single(input string tag, input logic ch, input logic wr,
                        input logic [9:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    if (ch) begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; end
    else    begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d; end
    tick();
    chk({tag, ".acc_wr"},   32'(mem_wr_rd), 32'(wr));
    chk({tag, ".acc_addr"}, 32'(mem_addr),  32'(a));
    if (wr) chk({tag, ".acc_data"}, 32'(mem_i_data), 32'(d));
    chk({tag, ".acc_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".cap_wr"},  32'(mem_wr_rd), 32'd0);
    chk({tag, ".cap_ack"}, 32'({ack1, ack0}), 32'd0);
    tick();
    chk({tag, ".ack"}, 32'({ack1, ack0}), ch ? 32'd2 : 32'd1);
    chk({tag, ".done_wr"}, 32'(mem_wr_rd), 32'd0);
    if (!wr) chk({tag, ".rdata"}, ch ? 32'(rdata1) : 32'(rdata0), 32'(exp_rd));
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk({tag, ".idle_ack"},  32'({ack1, ack0}), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_p = 1'b1;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;

    // 1. reset and idle
    tick(); tick();
    chk("rst.outs", 32'({ack0, ack1, busy, mem_wr_rd}), 32'd0);
    chk("rst.addr", 32'(mem_addr), 32'd0);
    chk("rst.idata", 32'(mem_i_data), 32'd0);
    chk("rst.rdata", 32'({rdata0, rdata1}), 32'd0);
    reset_p = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle.outs", 32'({ack0, ack1, busy, mem_wr_rd}), 32'd0);
    end

    // 2. single write then read on ch0
    single("wr005", 1'b0, 1'b1, 10'h005, 8'hA5, 8'h00);
    single("rd005", 1'b0, 1'b0, 10'h005, 8'h00, 8'hA5);

    // 3. simultaneous writes after reset: ch0 first
    reset_p = 1'b1; tick(); reset_p = 1'b0;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 10'h010; wdata0 = 8'h11;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 10'h020; wdata1 = 8'h22;
    tick();
    chk("sim.a0_wr",   32'(mem_wr_rd),  32'd1);
    chk("sim.a0_addr", 32'(mem_addr),   32'h010);
    chk("sim.a0_data", 32'(mem_i_data), 32'h11);
    tick();
    chk("sim.c0_ack", 32'({ack1, ack0}), 32'd0);
    tick();
    chk("sim.ack0", 32'({ack1, ack0}), 32'd1);
    req0 = 1'b0;
    tick();
    chk("sim.idle", 32'({ack1, ack0, busy}), 32'd0);
    tick();
    chk("sim.a1_wr",   32'(mem_wr_rd),  32'd1);
    chk("sim.a1_addr", 32'(mem_addr),   32'h020);
    chk("sim.a1_data", 32'(mem_i_data), 32'h22);
    tick(); tick();
    chk("sim.ack1", 32'({ack1, ack0}), 32'd2);
    req1 = 1'b0;
    tick();
    chk("sim.idle2", 32'({ack1, ack0, busy}), 32'd0);
    single("rb010", 1'b0, 1'b0, 10'h010, 8'h00, 8'h11);
    single("rb020", 1'b1, 1'b0, 10'h020, 8'h00, 8'h22);

    // 4. fairness: both reads held for six grants
    req0 = 1'b1; wr0 = 1'b0; addr0 = 10'h010;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 10'h020;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fair.addr", 32'(mem_addr), (k % 2) ? 32'h020 : 32'h010);
      chk("fair.wr", 32'(mem_wr_rd), 32'd0);
      tick(); tick();
      chk("fair.ack", 32'({ack1, ack0}), (k % 2) ? 32'd2 : 32'd1);
      chk("fair.rdata", (k % 2) ? 32'(rdata1) : 32'(rdata0), (k % 2) ? 32'h22 : 32'h11);
      if (k == 5) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      chk("fair.gap", 32'({ack1, ack0}), 32'd0);
    end

    // 5. input changes after sampling are ignored
    single("wr030", 1'b0, 1'b1, 10'h030, 8'h3C, 8'h00);
    single("wr031", 1'b0, 1'b1, 10'h031, 8'h3D, 8'h00);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 10'h030;
    tick();
    chk("hold.acc_addr", 32'(mem_addr), 32'h030);
    addr0 = 10'h031;
    tick();
    chk("hold.cap_addr", 32'(mem_addr), 32'h030);
    tick();
    chk("hold.ack", 32'({ack1, ack0}), 32'd1);
    chk("hold.rdata", 32'(rdata0), 32'h3C);
    req0 = 1'b0;
    tick();

    // 6. reset during CAPTURE of a ch1 read
    req1 = 1'b1; wr1 = 1'b0; addr1 = 10'h020;
    tick();
    chk("rmid.acc_addr", 32'(mem_addr), 32'h020);
    tick();
    reset_p = 1'b1;
    tick();
    chk("rmid.ack", 32'({ack1, ack0}), 32'd0);
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.rdata1", 32'(rdata1), 32'd0);
    chk("rmid.rdata0", 32'(rdata0), 32'd0);
    reset_p = 1'b0;
    tick();
    chk("rmid.again_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("rmid.again_ack", 32'({ack1, ack0}), 32'd2);
    chk("rmid.again_rdata", 32'(rdata1), 32'h22);
    req1 = 1'b0;
    tick();
    chk("rmid.end", 32'({ack1, ack0, busy}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Two-channel round-robin arbiter and sequencer that shares one single-port RAM between two requesters. The RAM has one address bus, a wr_rd select and a registered read port. The block latches a request, drives the RAM for exactly one access cycle, captures the read data and returns a one-cycle ack to the winning channel. It sits between two client blocks (e.g. a SIPO capture path and a PISO/display path) and the RAM instance.

Parameters:
ADDR_W, 10, RAM address width (1024 words)
DATA_W, 8, RAM data width

Ports:
clk  input  1  system clock; all logic on posedge
reset_p  input  1  synchronous, active-high reset, sampled on posedge clk
req0  input  1  channel 0 request (level)
wr0  input  1  channel 0 op: 1 = write, 0 = read; sampled with req0
addr0  input  ADDR_W  channel 0 address
wdata0  input  DATA_W  channel 0 write data
ack0  output  1  one-cycle completion pulse, channel 0
rdata0  output  DATA_W  channel 0 read data, valid while ack0=1, held after
req1, wr1, addr1, wdata1, ack1, rdata1  same as channel 0 for channel 1
busy  output  1  1 in any state other than IDLE
mem_wr_rd  output  1  to RAM wr_rd: 1 = write this cycle, 0 = read
mem_addr  output  ADDR_W  to RAM addr
mem_i_data  output  DATA_W  to RAM i_data
mem_o_data  input  DATA_W  from RAM o_data (updated on the posedge after addr is presented)

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset_p). All outputs are registered.
- Reset values: state=IDLE, ack0=ack1=0, rdata0=rdata1=0, busy=0, mem_wr_rd=0, mem_addr=0, mem_i_data=0, last_grant=1 (so channel 0 wins the first tie).
- FSM states: IDLE -> ACCESS -> CAPTURE -> DONE -> IDLE. No other transitions.
- IDLE:
  - If no request is asserted, stay in IDLE.
  - Otherwise pick a winner. Only one req high: that channel wins. Both high: the channel != last_grant wins.
  - On the same edge, register mem_addr, mem_i_data and mem_wr_rd (= the winner's wr bit), record the grant, update last_grant, and go to ACCESS.
- ACCESS (1 cycle): the RAM operation is presented. The RAM writes or reads at the closing edge. Go to CAPTURE and force mem_wr_rd=0 on that edge.
- CAPTURE (1 cycle):
  - Read: load mem_o_data into rdata of the granted channel at the closing edge.
  - Write: rdata of that channel is unchanged.
  - Set the granted channel's ack=1 and go to DONE.
- DONE (1 cycle): ack=1 for the granted channel only. At the closing edge, clear ack and go to IDLE.
- Latency: req sampled at edge N -> ack high during cycle N+3 -> IDLE re-samples reqs at edge N+4.
- Requester rule: hold req, wr, addr and wdata stable until ack is seen, then deassert req at the edge ending the ack cycle. A req still high at edge N+4 starts a new transaction.
- Request inputs are sampled only in IDLE. Changes in any other state are ignored.
- The non-granted channel stays pending. Its req remains high and it wins the next IDLE arbitration, because last_grant points to the other channel.
- ack0 and ack1 are never high in the same cycle.
- mem_wr_rd is 1 only during a write's ACCESS cycle. Default 0 means any stray RAM read is harmless.
- Reset mid-operation: the FSM returns to IDLE and acks clear at the reset edge. The in-flight transaction is dropped without ack.
  - If reset lands on the edge closing a write's ACCESS cycle, the RAM still performs that write (the RAM has no reset). This is accepted behaviour.
- Address and data are passed through unmodified. No wrap or range checks, since the full ADDR_W space is valid.

Test Plan:
1. Reset: hold reset_p 2 cycles -> all outputs 0, busy=0. Release with no req -> idle indefinitely, mem_wr_rd=0.
2. Single write/read: ch0 write addr=0x005 data=0xA5 -> mem_wr_rd=1 exactly one cycle, ack0 at cycle N+3. Then ch0 read addr=0x005 -> rdata0=0xA5 with ack0, ack1 never asserted.
3. Simultaneous reqs after reset: ch0 write 0x010<-0x11, ch1 write 0x020<-0x22 -> ch0 acked first, ch1 acked 4 cycles later. Read-backs return 0x11 and 0x22.
4. Fairness: both channels hold reads continuously for 6 transactions -> grants alternate 0,1,0,1,0,1, each ack separated by 4 cycles.
5. Ignore mid-transaction changes: change addr0 from 0x030 to 0x031 during ACCESS/CAPTURE -> RAM sees 0x030 only. Read returns the value at 0x030.
6. Reset mid-read: assert reset_p during CAPTURE of a ch1 read -> no ack1, rdata1=0, state IDLE next cycle. A following ch1 read completes normally.
